// File: rtl/slc3_mem_ctrl_if.sv
// Bus bundle between the SLC-3 control FSM, the memory-access stage and the async SRAM.
// master: control FSM plus SRAM data return; slave: slc3_mem_ctrl.
`timescale 1ns/1ps
interface slc3_mem_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata_out;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_ce_n;
    logic              mem_oe_n;
    logic              mem_we_n;

    modport master (
        output req, we, addr_in, wdata_in, mem_dout,
        input  ready, done, rdata_out, mem_addr, mem_din, mem_ce_n, mem_oe_n, mem_we_n
    );

    modport slave (
        input  req, we, addr_in, wdata_in, mem_dout,
        output ready, done, rdata_out, mem_addr, mem_din, mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory-access stage: MAR/MDR plus a fixed-wait-state async SRAM sequencer.
// Define SLC3_MEM_B2B_EN to accept a new request in the DONE cycle (zero-bubble back-to-back).
`timescale 1ns/1ps
module slc3_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 16
) (
    input logic           Clk,
    input logic           Reset_n,
    slc3_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              accept;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            mar_q   <= '0;
            mdr_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = bus.req;
            end
            ACCESS: begin
                cnt_d = 4'(cnt_q + 4'd1);
                if (cnt_q == WC) begin
                    state_d = DONE;
                    if (!op_q) begin
                        mdr_d = bus.mem_dout;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SLC3_MEM_B2B_EN
                accept = bus.req;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = ACCESS;
            cnt_d   = '0;
            op_d    = bus.we;
            mar_d   = bus.addr_in;
            if (bus.we) begin
                mdr_d = bus.wdata_in;
            end
        end

        // Outputs are registered from the next state so strobes never glitch.
`ifdef SLC3_MEM_B2B_EN
        ready_d = (state_d == IDLE) || (state_d == DONE);
`else
        ready_d = (state_d == IDLE);
`endif
        done_d = (state_d == DONE);
        ce_n_d = (state_d != ACCESS);
        oe_n_d = !((state_d == ACCESS) && !op_d);
        // Store drops WE on the last ACCESS cycle so address/data hold past the write edge.
        we_n_d = !((state_d == ACCESS) && op_d && (cnt_d != WC));
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.rdata_out = mdr_q;
    assign bus.mem_addr  = mar_q;
    assign bus.mem_din   = mdr_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_oe_n  = oe_n_q;
    assign bus.mem_we_n  = we_n_q;
endmodule

// File: doc/slc3_mem_ctrl.md
Name: slc3_mem_ctrl

Overview:
- Memory-access stage directly downstream of the ALU and the address adder.
- Latches the computed effective address into MAR and the store data into MDR (store data is the ALU pass-through result).
- Sequences a fixed-wait-state async SRAM read or write and returns load data in MDR.
- Gives the control FSM a ready/req/done handshake so LDR/STR/LD/ST-style states can stall on memory.

Parameters:
- WAIT_CYCLES, 2, SRAM cycles with strobes active before the access completes; legal range 1..15.
- DATA_W, 16, address and data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled only when ready=1.
- we  in  1  1=store, 0=load; sampled with req.
- addr_in  in  DATA_W  effective address from the address adder output.
- wdata_in  in  DATA_W  store data from the ALU output.
- ready  out  1  block idle and able to accept req.
- done  out  1  one-cycle pulse: access complete.
- rdata_out  out  DATA_W  MDR contents.
- mem_addr  out  DATA_W  MAR contents to SRAM.
- mem_din  out  DATA_W  data to SRAM; always equals MDR.
- mem_dout  in  DATA_W  data from SRAM.
- mem_ce_n  out  1  SRAM chip enable, active low.
- mem_oe_n  out  1  SRAM output enable, active low.
- mem_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; MAR=0, MDR=0, wait counter=0.
  - ready=1, done=0.
  - mem_ce_n=mem_oe_n=mem_we_n=1.
  - Takes effect immediately, including mid-access. An aborted access never produces done.
- All outputs are registered. Strobes are derived from next-state, so they are glitch-free.
- IDLE:
  - ready=1; all strobes high.
  - On a rising edge with req=1: MAR<=addr_in, latch op<=we; if we=1 then MDR<=wdata_in. Go to ACCESS; counter<=0.
  - req=0: remain in IDLE.
- ACCESS, lasting exactly WAIT_CYCLES+1 cycles:
  - ready=0; mem_ce_n=0 throughout.
  - Load: mem_oe_n=0 throughout. On the final ACCESS edge, MDR<=mem_dout.
  - Store: mem_we_n=0 for the first WAIT_CYCLES cycles, then 1 on the final cycle (data/address hold). mem_oe_n=1.
  - Counter increments each cycle. Leave ACCESS when counter==WAIT_CYCLES.
- DONE, one cycle:
  - done=1, ready=0, all strobes high.
  - Next state IDLE.
- Latency: with acceptance at edge 0, done is high in cycle WAIT_CYCLES+2 and ready returns in cycle WAIT_CYCLES+3.
- req while ready=0 is ignored, not queued. A req held high across a whole access is re-accepted at the next IDLE edge.
- MDR persistence:
  - A store overwrites MDR with the store data.
  - rdata_out holds until the next accepted store or completed load.
- MAR holds the last accepted address, including after the access completes.
- No address wrap logic: addresses 0x0000..0xFFFF pass through unchanged.
- addr_in, wdata_in and we are don't-care except on the accept edge.

Optional Feature:
- Macro: SLC3_MEM_B2B_EN.
- Defined:
  - ready=1 also in the DONE state, and a req sampled in DONE is accepted exactly as in IDLE.
  - Next state is ACCESS with zero bubble; done still pulses for the finishing access.
  - Strobes go high for the DONE cycle regardless.
- Undefined: ready=0 in DONE and a req in DONE is ignored (one idle cycle minimum between accesses).

Test Plan (WAIT_CYCLES=2 unless stated):
- Reset: hold Reset_n=0 with random inputs -> ready=1, done=0, all strobes 1, mem_addr=0x0000, rdata_out=0x0000.
- Load: req=1, we=0, addr_in=0x3000, mem_dout=0xBEEF at edge 0 -> cycles 1-3 mem_ce_n=mem_oe_n=0, mem_we_n=1, mem_addr=0x3000; done=1 in cycle 4 with rdata_out=0xBEEF; ready=1 in cycle 5.
- Store: req=1, we=1, addr_in=0x3001, wdata_in=0x1234 -> mem_din=0x1234 from cycle 1; mem_we_n=0 in cycles 1-2 and 1 in cycle 3; mem_ce_n=0 in cycles 1-3; done in cycle 4; rdata_out=0x1234.
- req held high for 10 cycles with addr_in=0x4000 -> second access starts only after ready returns. Without SLC3_MEM_B2B_EN, accepts occur at edges 0 and 5; with it, at edges 0 and 4, and done pulses in cycles 4 and 8.
- Reset_n pulled low during cycle 2 of a store to 0x5000 -> mem_we_n and mem_ce_n go 1 immediately (async); no done pulse; ready=1 after release; the next load proceeds normally.
- WAIT_CYCLES=1: load addr_in=0xFFFF, mem_dout=0x0000 -> strobes low in cycles 1-2, done in cycle 3, rdata_out=0x0000, mem_addr=0xFFFF.
